// File: rtl/claa_serial_ctrl.sv
// Nibble-serial multi-precision add/subtract sequencer driving an external
// 4-bit carry-lookahead adder one slice per cycle, LSB nibble first.
module claa_serial_ctrl #(
    parameter int WIDTH = 16  // multiple of 4, >= 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_s,
    input  logic             cla_c3,
    input  logic             cla_c4
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    // Slice offset is idx*4; concatenation keeps the select width explicit.
    logic [IDX_W+1:0]   bit_ofs;
    assign bit_ofs = {idx, 2'b00};

    // in_ready is held low while reset is asserted so every output reads 0.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    // The claa is combinational, so the slice is presented in the same cycle.
    assign cla_a   = (state == RUN) ? a_reg[bit_ofs +: 4] : 4'h0;
    assign cla_b   = (state == RUN) ? b_reg[bit_ofs +: 4] : 4'h0;
    assign cla_cin = (state == RUN) ? carry : 1'b0;

    // NOTE: every register, including the operand latches, is cleared by the
    // async reset so an aborted operation leaves no trace behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                        b_reg <= sub ? ~op_b : op_b;
                        carry <= sub;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[bit_ofs +: 4] <= cla_s;
                    carry <= cla_c4;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout  <= cla_c4;
                        ovf   <= cla_c3 ^ cla_c4;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
